// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the instruction-fetch requester
// (read-only) and the load/store requester (read/write with byte mask).
// Data wins by default; a streak counter forces a fetch grant once MAX_D_BURST
// consecutive data grants have been made while fetch was pending. A watchdog
// aborts a granted access that never sees mem_ready.
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int MAX_D_BURST = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic                  CLK,
    input  logic                  RESET,
    // instruction fetch requester
    input  logic                  i_valid,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ready,
    output logic [31:0]           i_rdata,
    output logic                  i_err,
    // load/store requester
    input  logic                  d_valid,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    input  logic [3:0]            d_wmask,
    output logic                  d_ready,
    output logic [31:0]           d_rdata,
    output logic                  d_err,
    // memory port
    output logic                  mem_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wmask,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    // state trace
    output logic [1:0]            state_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT_I = 2'd1,
        S_GRANT_D = 2'd2
    } state_t;

    localparam int SW = $clog2(MAX_D_BURST + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_BURST);
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int WD_LAST_INT = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [WW-1:0] WD_LAST = WW'(WD_LAST_INT);
    localparam bit WD_EN = (TIMEOUT > 0);

    state_t          state_r;
    logic [SW-1:0]   streak_r;
    logic [WW-1:0]   wdog_r;

    logic            i_elig_s;
    logic            d_elig_s;
    logic            grant_i_s;
    logic            grant_d_s;
    logic [SW-1:0]   streak_next_s;
    logic            wd_expire_s;

    assign state_out = state_r;

    // Arbitration: a requester is never re-granted in its own completion cycle.
    always_comb begin
        i_elig_s  = i_valid & ~i_ready;
        d_elig_s  = d_valid & ~d_ready;
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        if ((streak_r == STREAK_MAX) && i_elig_s) begin
            grant_i_s = 1'b1;
        end else if (d_elig_s) begin
            grant_d_s = 1'b1;
        end else if (i_elig_s) begin
            grant_i_s = 1'b1;
        end else begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
        end
    end

    // Streak value after a data grant: counts only while fetch is waiting, saturating.
    always_comb begin
        streak_next_s = streak_r;
        if (!i_valid) begin
            streak_next_s = '0;
        end else if (streak_r == STREAK_MAX) begin
            streak_next_s = streak_r;
        end else begin
            streak_next_s = streak_r + SW'(1);
        end
    end

    // Watchdog expiry: this stalled grant cycle is the TIMEOUT-th one.
    always_comb begin
        wd_expire_s = 1'b0;
        if (WD_EN && (wdog_r == WD_LAST)) begin
            wd_expire_s = 1'b1;
        end else begin
            wd_expire_s = 1'b0;
        end
    end

    // Main FSM with all outputs registered; ready pulses last one cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r   <= S_IDLE;
            streak_r  <= '0;
            wdog_r    <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0000_0000;
            mem_wmask <= 4'b0000;
            i_ready   <= 1'b0;
            i_rdata   <= 32'h0000_0000;
            i_err     <= 1'b0;
            d_ready   <= 1'b0;
            d_rdata   <= 32'h0000_0000;
            d_err     <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    wdog_r <= '0;
                    if (grant_d_s) begin
                        state_r   <= S_GRANT_D;
                        mem_valid <= 1'b1;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_wmask <= d_wmask;
                        streak_r  <= streak_next_s;
                    end else if (grant_i_s) begin
                        state_r   <= S_GRANT_I;
                        mem_valid <= 1'b1;
                        mem_addr  <= i_addr;
                        mem_wdata <= 32'h0000_0000;
                        mem_wmask <= 4'b0000;
                        streak_r  <= '0;
                    end else begin
                        mem_valid <= 1'b0;
                    end
                end
                S_GRANT_I: begin
                    if (mem_ready) begin
                        state_r   <= S_IDLE;
                        mem_valid <= 1'b0;
                        i_ready   <= 1'b1;
                        i_rdata   <= mem_rdata;
                        i_err     <= 1'b0;
                        wdog_r    <= '0;
                    end else if (wd_expire_s) begin
                        state_r   <= S_IDLE;
                        mem_valid <= 1'b0;
                        i_ready   <= 1'b1;
                        i_rdata   <= 32'h0000_0000;
                        i_err     <= 1'b1;
                        wdog_r    <= '0;
                    end else if (WD_EN) begin
                        wdog_r    <= wdog_r + WW'(1);
                    end else begin
                        wdog_r    <= wdog_r;
                    end
                end
                S_GRANT_D: begin
                    if (mem_ready) begin
                        state_r   <= S_IDLE;
                        mem_valid <= 1'b0;
                        d_ready   <= 1'b1;
                        d_rdata   <= mem_rdata;
                        d_err     <= 1'b0;
                        wdog_r    <= '0;
                    end else if (wd_expire_s) begin
                        state_r   <= S_IDLE;
                        mem_valid <= 1'b0;
                        d_ready   <= 1'b1;
                        d_rdata   <= 32'h0000_0000;
                        d_err     <= 1'b1;
                        wdog_r    <= '0;
                    end else if (WD_EN) begin
                        wdog_r    <= wdog_r + WW'(1);
                    end else begin
                        wdog_r    <= wdog_r;
                    end
                end
                default: begin
                    // unused encoding: drop any request and recover to IDLE
                    state_r   <= S_IDLE;
                    mem_valid <= 1'b0;
                    wdog_r    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scenario tasks drive the two requesters; a memory responder
// answers one cycle after mem_valid; a monitor pops expected completions from
// per-requester scoreboard queues whenever a ready pulse appears.
// MAX_D_BURST is set to 1 here: with the one-grant-per-completion handshake
// the streak can only build by one between fetch grants, so a limit of 1 is
// what makes the forced-fetch branch observable.
module tb_mem_arbiter;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        CLK;
    logic        RESET;
    logic        i_valid;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_valid;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [1:0]  state_out;

    int   vectors     = 0;
    int   miscompares = 0;
    bit   resp_en     = 1'b1;
    int   stray_n     = 0;
    exp_t iq[$];
    exp_t dq[$];

    mem_arbiter #(
        .ADDR_WIDTH (32),
        .MAX_D_BURST(1),
        .TIMEOUT    (8)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .i_valid  (i_valid),
        .i_addr   (i_addr),
        .i_ready  (i_ready),
        .i_rdata  (i_rdata),
        .i_err    (i_err),
        .d_valid  (d_valid),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wmask  (d_wmask),
        .d_ready  (d_ready),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .mem_valid(mem_valid),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .state_out(state_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory contents model.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h0000_0093;
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory responder: one-cycle strobe in the first cycle mem_valid is seen.
    always @(negedge CLK) begin
        if (resp_en && mem_valid && !mem_ready) begin
            mem_ready = 1'b1;
            mem_rdata = mem_fn(mem_addr);
        end else if (stray_n > 0) begin
            mem_ready = 1'b1;
            mem_rdata = 32'hBAD0_BAD0;
            stray_n   = stray_n - 1;
        end else begin
            mem_ready = 1'b0;
        end
    end

    // Completion monitor and scoreboard.
    always @(negedge CLK) begin
        exp_t e;
        vectors++;
        if (i_ready === 1'b1 && d_ready === 1'b1) begin
            $display("FAIL both_ready: i_ready=%b d_ready=%b, required not both", i_ready, d_ready);
            miscompares++;
        end
        vectors++;
        if (state_out === 2'd0 && mem_valid === 1'b1) begin
            $display("FAIL idle_mem_valid: mem_valid=%b in IDLE, required 0", mem_valid);
            miscompares++;
        end
        if (i_ready === 1'b1) begin
            vectors++;
            if (iq.size() == 0) begin
                $display("FAIL i_spurious: i_ready=1 with no fetch outstanding");
                miscompares++;
            end else begin
                e = iq.pop_front();
                if (i_rdata !== e.rdata || i_err !== e.err) begin
                    $display("FAIL i_result: got rdata=%h err=%b, required rdata=%h err=%b",
                             i_rdata, i_err, e.rdata, e.err);
                    miscompares++;
                end
            end
        end
        if (d_ready === 1'b1) begin
            vectors++;
            if (dq.size() == 0) begin
                $display("FAIL d_spurious: d_ready=1 with no data access outstanding");
                miscompares++;
            end else begin
                e = dq.pop_front();
                if (d_rdata !== e.rdata || d_err !== e.err) begin
                    $display("FAIL d_result: got rdata=%h err=%b, required rdata=%h err=%b",
                             d_rdata, d_err, e.rdata, e.err);
                    miscompares++;
                end
            end
        end
    end

    task automatic test_reset();
        RESET = 1'b1; i_valid = 1'b0; i_addr = 32'h0; d_valid = 1'b0; d_addr = 32'h0;
        d_wdata = 32'h0; d_wmask = 4'b0000; mem_ready = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge CLK);
        vectors++;
        if ({state_out, mem_valid, i_ready, d_ready, i_err, d_err} !== 7'b0) begin
            $display("FAIL reset_ctrl: state=%0d mv=%b ir=%b dr=%b ie=%b de=%b, required all 0",
                     state_out, mem_valid, i_ready, d_ready, i_err, d_err);
            miscompares++;
        end
        vectors++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wmask !== 4'b0000 ||
            i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            $display("FAIL reset_data: addr=%h wd=%h wm=%b ird=%h drd=%h, required all 0",
                     mem_addr, mem_wdata, mem_wmask, i_rdata, d_rdata);
            miscompares++;
        end
        RESET = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_fetch();
        i_valid = 1'b1; i_addr = 32'h0000_0010;
        iq.push_back('{rdata: 32'h0000_0093, err: 1'b0});
        @(negedge CLK);
        vectors++;
        if (state_out !== 2'd1 || mem_valid !== 1'b1 || mem_addr !== 32'h10 || mem_wmask !== 4'b0000) begin
            $display("FAIL fetch_grant: state=%0d mv=%b addr=%h wm=%b, required 1 1 00000010 0000",
                     state_out, mem_valid, mem_addr, mem_wmask);
            miscompares++;
        end
        @(negedge CLK);
        vectors++;
        if (i_ready !== 1'b1 || state_out !== 2'd0) begin
            $display("FAIL fetch_done: i_ready=%b state=%0d, required 1 0", i_ready, state_out);
            miscompares++;
        end
        @(negedge CLK);
        i_valid = 1'b0;
        vectors++;
        if (i_ready !== 1'b0) begin
            $display("FAIL fetch_pulse: i_ready=%b one cycle later, required 0", i_ready);
            miscompares++;
        end
        @(negedge CLK);
    endtask

    task automatic test_both_rise();
        i_valid = 1'b1; i_addr = 32'h0000_0040;
        d_valid = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'h1234_5678; d_wmask = 4'b1111;
        dq.push_back('{rdata: mem_fn(32'h100), err: 1'b0});
        iq.push_back('{rdata: mem_fn(32'h40), err: 1'b0});
        @(negedge CLK);
        vectors++;
        if (state_out !== 2'd2 || mem_wmask !== 4'b1111 || mem_addr !== 32'h100 || mem_wdata !== 32'h1234_5678) begin
            $display("FAIL both_data_first: state=%0d wm=%b addr=%h wd=%h, required 2 1111 00000100 12345678",
                     state_out, mem_wmask, mem_addr, mem_wdata);
            miscompares++;
        end
        @(negedge CLK);
        vectors++;
        if (d_ready !== 1'b1 || i_ready !== 1'b0) begin
            $display("FAIL both_d_done: d_ready=%b i_ready=%b, required 1 0", d_ready, i_ready);
            miscompares++;
        end
        @(negedge CLK);
        d_valid = 1'b0;
        vectors++;
        if (state_out !== 2'd1 || mem_addr !== 32'h40 || mem_wmask !== 4'b0000 || mem_wdata !== 32'h0) begin
            $display("FAIL both_fetch_next: state=%0d addr=%h wm=%b wd=%h, required 1 00000040 0000 0",
                     state_out, mem_addr, mem_wmask, mem_wdata);
            miscompares++;
        end
        @(negedge CLK);
        vectors++;
        if (i_ready !== 1'b1) begin
            $display("FAIL both_i_done: i_ready=%b, required 1", i_ready);
            miscompares++;
        end
        @(negedge CLK);
        i_valid = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_streak();
        i_valid = 1'b1; i_addr = 32'h0000_0080;
        iq.push_back('{rdata: mem_fn(32'h80), err: 1'b0});
        @(negedge CLK);
        @(negedge CLK);
        vectors++;
        if (i_ready !== 1'b1) begin
            $display("FAIL streak_i1_done: i_ready=%b, required 1", i_ready);
            miscompares++;
        end
        // data raised in fetch's completion cycle while i_valid is still high
        d_valid = 1'b1; d_addr = 32'h0000_0300; d_wdata = 32'h0; d_wmask = 4'b0000;
        dq.push_back('{rdata: mem_fn(32'h300), err: 1'b0});
        @(negedge CLK);
        i_valid = 1'b0;
        vectors++;
        if (state_out !== 2'd2 || mem_addr !== 32'h300) begin
            $display("FAIL streak_d1_grant: state=%0d addr=%h, required 2 00000300", state_out, mem_addr);
            miscompares++;
        end
        @(negedge CLK);
        vectors++;
        if (d_ready !== 1'b1) begin
            $display("FAIL streak_d1_done: d_ready=%b, required 1", d_ready);
            miscompares++;
        end
        @(negedge CLK);
        vectors++;
        if (state_out !== 2'd0) begin
            $display("FAIL streak_idle: state=%0d, required 0", state_out);
            miscompares++;
        end
        // both requesters pending together: streak at limit forces fetch
        i_valid = 1'b1; i_addr = 32'h0000_0084;
        d_valid = 1'b1; d_addr = 32'h0000_0304;
        iq.push_back('{rdata: mem_fn(32'h84), err: 1'b0});
        dq.push_back('{rdata: mem_fn(32'h304), err: 1'b0});
        @(negedge CLK);
        vectors++;
        if (state_out !== 2'd1 || mem_addr !== 32'h84) begin
            $display("FAIL streak_forced_fetch: state=%0d addr=%h, required 1 00000084", state_out, mem_addr);
            miscompares++;
        end
        @(negedge CLK);
        vectors++;
        if (i_ready !== 1'b1) begin
            $display("FAIL streak_i2_done: i_ready=%b, required 1", i_ready);
            miscompares++;
        end
        @(negedge CLK);
        i_valid = 1'b0;
        vectors++;
        if (state_out !== 2'd2 || mem_addr !== 32'h304) begin
            $display("FAIL streak_back_to_data: state=%0d addr=%h, required 2 00000304", state_out, mem_addr);
            miscompares++;
        end
        @(negedge CLK);
        vectors++;
        if (d_ready !== 1'b1) begin
            $display("FAIL streak_d2_done: d_ready=%b, required 1", d_ready);
            miscompares++;
        end
        @(negedge CLK);
        d_valid = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_timeout();
        int bad;
        resp_en = 1'b0;
        d_valid = 1'b1; d_addr = 32'h0000_0400; d_wdata = 32'h0; d_wmask = 4'b0000;
        dq.push_back('{rdata: 32'h0, err: 1'b1});
        bad = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (mem_valid !== 1'b1 || d_ready !== 1'b0 || state_out !== 2'd2) bad = k;
        end
        vectors++;
        if (bad != 0) begin
            $display("FAIL timeout_wait: early abort or no grant at wait cycle %0d, required 8 waiting cycles", bad);
            miscompares++;
        end
        @(negedge CLK);
        vectors++;
        if (d_ready !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0 || mem_valid !== 1'b0 || state_out !== 2'd0) begin
            $display("FAIL timeout_abort: dr=%b de=%b drd=%h mv=%b state=%0d, required 1 1 0 0 0",
                     d_ready, d_err, d_rdata, mem_valid, state_out);
            miscompares++;
        end
        @(negedge CLK);
        d_valid = 1'b0;
        stray_n = 2;
        bad = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            if (d_ready !== 1'b0 || i_ready !== 1'b0 || state_out !== 2'd0) bad = k;
        end
        vectors++;
        if (bad != 0) begin
            $display("FAIL stray_ready: pulse or state change at cycle %0d after stray mem_ready, required none", bad);
            miscompares++;
        end
        resp_en = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        bit got;
        resp_en = 1'b0;
        i_valid = 1'b1; i_addr = 32'h0000_0500;
        @(negedge CLK);
        vectors++;
        if (state_out !== 2'd1) begin
            $display("FAIL rmid_grant: state=%0d, required 1", state_out);
            miscompares++;
        end
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        i_valid = 1'b0;
        vectors++;
        if (mem_valid !== 1'b0 || state_out !== 2'd0 || i_ready !== 1'b0 || mem_addr !== 32'h0) begin
            $display("FAIL rmid_reset: mv=%b state=%0d ir=%b addr=%h, required 0 0 0 0",
                     mem_valid, state_out, i_ready, mem_addr);
            miscompares++;
        end
        resp_en = 1'b1;
        repeat (2) @(negedge CLK);
        i_valid = 1'b1; i_addr = 32'h0000_0504;
        iq.push_back('{rdata: mem_fn(32'h504), err: 1'b0});
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge CLK);
            if (i_ready === 1'b1) got = 1'b1;
        end
        vectors++;
        if (!got) begin
            $display("FAIL rmid_refetch: i_ready=0 after 20 cycles, required completion");
            miscompares++;
        end
        @(negedge CLK);
        i_valid = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_store();
        int  bad;
        bit  got;
        resp_en = 1'b0;
        d_valid = 1'b1; d_addr = 32'h0000_0204; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'b0011;
        dq.push_back('{rdata: mem_fn(32'h204), err: 1'b0});
        bad = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            if (mem_valid !== 1'b1 || mem_addr !== 32'h204 || mem_wmask !== 4'b0011 ||
                mem_wdata !== 32'hDEAD_BEEF) bad = k;
        end
        vectors++;
        if (bad != 0) begin
            $display("FAIL store_hold: cycle %0d mv=%b addr=%h wm=%b wd=%h, required 1 00000204 0011 deadbeef",
                     bad, mem_valid, mem_addr, mem_wmask, mem_wdata);
            miscompares++;
        end
        resp_en = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge CLK);
            if (d_ready === 1'b1) got = 1'b1;
        end
        vectors++;
        if (!got || mem_valid !== 1'b0 || d_err !== 1'b0) begin
            $display("FAIL store_done: got=%b mv=%b de=%b, required 1 0 0", got, mem_valid, d_err);
            miscompares++;
        end
        @(negedge CLK);
        d_valid = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_both_rise();
        test_streak();
        test_timeout();
        test_reset_mid();
        test_store();
        repeat (2) @(negedge CLK);
        vectors++;
        if (iq.size() != 0 || dq.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d fetch and %0d data completions missing, required 0 0",
                     iq.size(), dq.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
